// File: rtl/lead_one_rr_arbiter_if.sv
// Request/grant bundle between requester front-ends (master) and the
// round-robin arbiter (slave).
interface lead_one_rr_arbiter_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 4
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/lead_one_rr_arbiter.sv
// Round-robin arbiter: leading-one pick over requests below the last winner,
// wrapping to the full request vector; grants held until done, withdraw or timeout.
module lead_one_rr_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lead_one_rr_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CW-1:0]    hold_q, hold_d;

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] win_idx;
  logic             owner_req;
  logic             hold_max;
  logic             release_now;

  // One-based index of the highest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lead_one(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (v[k]) r = IDX_W'(k + 1);
    end
    return r;
  endfunction

  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < N; k++) begin
      mask[k] = (IDX_W'(k) < last_q);
    end
    masked      = bus.req & mask;
    win_idx     = (|masked) ? lead_one(masked) : lead_one(bus.req);
    owner_req   = |(bus.req & grant_q);
    hold_max    = (hold_q == CW'(MAX_HOLD));
    release_now = bus.done | ~owner_req | hold_max;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|bus.req) state_d = BUSY;
      BUSY: if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
        if (|bus.req) begin
          for (int unsigned k = 0; k < N; k++) begin
            grant_d[k] = (win_idx == IDX_W'(k + 1));
          end
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = CW'(1);
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_d   = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          hold_d    = '0;
          last_d    = idx_q - IDX_W'(1);
          // Timeout only when the hold limit alone forced the release.
          timeout_d = hold_max & ~bus.done & owner_req;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_lead_one_rr_arbiter.sv
// Directed bench for lead_one_rr_arbiter: vector table plus hand sequences
// for round-robin rotation, timeout and mid-grant reset.
module tb_lead_one_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lead_one_rr_arbiter_if #(.N(8), .IDX_W(4)) bus();

  lead_one_rr_arbiter #(.N(8), .IDX_W(4), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [3:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[13];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] g, input logic [3:0] idx,
                       input logic v, input logic to);
    checks++;
    if (bus.grant !== g || bus.grant_idx !== idx || bus.grant_valid !== v ||
        bus.timeout !== to || !$onehot0(bus.grant)) begin
      failures++;
      $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
               name, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout, g, idx, v, to);
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] q, input logic d);
    rst_n    = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;

    // reset, priority/latency, idle done, withdraw, ignore other requesters
    vecs[0]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h1E, 1'b0, 8'h10, 4'd5, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h1E, 1'b0, 8'h10, 4'd5, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h1E, 1'b0, 8'h10, 4'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h1E, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 8'h04, 4'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h84, 1'b0, 8'h04, 4'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h80, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h80, 1'b0, 8'h80, 4'd8, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h80, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid, vecs[i].tmo);
    end

    // Round robin with all requesting; last winner was bit 7.
    e = 7;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] g;
      g = 8'h01 << (e - 1);
      cycle(1'b1, 8'hFF, 1'b0);
      check($sformatf("rr_grant%0d", i), g, 4'(e), 1'b1, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1);
      check($sformatf("rr_idle%0d", i), 8'h00, 4'd0, 1'b0, 1'b0);
      e = (e == 1) ? 8 : e - 1;
    end

    // Timeout: held exactly 16 cycles, one timeout/idle cycle, then re-grant.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h01, 1'b0);
      check($sformatf("tmo_hold%0d", i), 8'h01, 4'd1, 1'b1, 1'b0);
    end
    cycle(1'b1, 8'h01, 1'b0);
    check("tmo_pulse", 8'h00, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h01, 1'b0);
    check("tmo_regrant", 8'h01, 4'd1, 1'b1, 1'b0);

    // done coinciding with the hold limit is a normal release.
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 8'h01, 1'b0);
      check($sformatf("lim_hold%0d", i), 8'h01, 4'd1, 1'b1, 1'b0);
    end
    cycle(1'b1, 8'h01, 1'b1);
    check("lim_done_no_tmo", 8'h00, 4'd0, 1'b0, 1'b0);

    // Leave last=3, then reset mid-grant of idx 6.
    cycle(1'b1, 8'h08, 1'b0);
    check("pre_idx4", 8'h08, 4'd4, 1'b1, 1'b0);
    cycle(1'b1, 8'h08, 1'b1);
    check("pre_rel4", 8'h00, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h20, 1'b0);
    check("busy_idx6", 8'h20, 4'd6, 1'b1, 1'b0);
    cycle(1'b1, 8'h20, 1'b0);
    check("busy_idx6_hold", 8'h20, 4'd6, 1'b1, 1'b0);
    cycle(1'b0, 8'h20, 1'b0);
    check("midop_reset", 8'h00, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h21, 1'b0);
    check("post_reset_last0", 8'h20, 4'd6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
